// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
//   state_e  : sequencer states (RUN, MEM_WAIT, FAULT)
//   REG_ZERO : hard-wired zero register specifier (never a real dependency)
//   *_DEF    : default parameter values for the top level
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int CNT_W_DEF      = 16;
  localparam int MAX_WAIT_DEF   = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
//   clk, reset : clock, synchronous active-high clear
//   inc        : count-enable for this cycle
//   count      : current value (W bits)
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// Central sequencer for a five-stage MIPS pipeline. Each cycle it decides
// whether the PC and the IF/ID, ID/EX, EX/MEM, MEM/WB registers load, hold
// or take a bubble, and whether the PC is redirected to the branch target.
//   Inputs : id_rs/id_rt (ID sources), idex_rt/idex_memread (load in EX),
//            exmem_branch/exmem_zero (branch in MEM), exmem_memread/
//            exmem_memwrite (MEM access), mem_ready (access completes)
//   Outputs: *_write load enables, ifid_flush/idex_bubble/exmem_bubble,
//            pc_src, sticky mem_timeout, stall_cycles/flush_events counters
// Control outputs are combinational (state + inputs); state, counters and
// mem_timeout update on the rising edge.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int MAX_WAIT   = MAX_WAIT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] idex_rt,
  input  logic                  idex_memread,
  input  logic                  exmem_branch,
  input  logic                  exmem_zero,
  input  logic                  exmem_memread,
  input  logic                  exmem_memwrite,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_write,
  output logic                  exmem_write,
  output logic                  memwb_write,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  exmem_bubble,
  output logic                  pc_src,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);

  localparam int WC_W = $clog2(MAX_WAIT + 1);

  state_e          state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            mem_timeout_q, mem_timeout_d;
  logic            mem_req, taken, load_use, freeze, last_wait;
  logic            stall_inc, flush_inc;

  assign mem_req  = exmem_memread | exmem_memwrite;
  assign taken    = exmem_branch & exmem_zero;
  assign load_use = idex_memread && (idex_rt != REG_ADDR_W'(REG_ZERO)) &&
                    ((idex_rt == id_rs) || (idex_rt == id_rt));
  // Current freeze cycle is number wait_cnt_q+1; the MAX_WAIT-th one without
  // mem_ready is the last one allowed before faulting.
  assign last_wait = (wait_cnt_q == WC_W'(MAX_WAIT - 1));

  always_comb begin
    pc_write      = 1'b0;
    ifid_write    = 1'b0;
    idex_write    = 1'b0;
    exmem_write   = 1'b0;
    memwb_write   = 1'b0;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    exmem_bubble  = 1'b0;
    pc_src        = 1'b0;
    state_d       = state_q;
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;

    // In MEM_WAIT the access is still outstanding, so mem_ready alone decides.
    case (state_q)
      RUN:      freeze = mem_req & ~mem_ready;
      MEM_WAIT: freeze = ~mem_ready;
      default:  freeze = 1'b0;
    endcase

    if (reset || (state_q == FAULT)) begin
      // everything held low; FAULT is only left through reset
    end else if (freeze) begin
      stall_inc  = 1'b1;
      wait_cnt_d = wait_cnt_q + 1'b1;
      if (last_wait) begin
        state_d       = FAULT;
        mem_timeout_d = 1'b1;
      end else begin
        state_d = MEM_WAIT;
      end
    end else begin
      state_d     = RUN;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_write  = 1'b1;
      exmem_write = 1'b1;
      memwb_write = 1'b1;
      if (taken) begin
        // Branch wins over load-use: the flush discards the dependent instr.
        pc_src       = 1'b1;
        ifid_flush   = 1'b1;
        idex_bubble  = 1'b1;
        exmem_bubble = 1'b1;
        flush_inc    = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        stall_inc   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_events)
  );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench: each driven cycle pushes a hand-computed expectation
// (control vector plus counter values visible during that cycle) into a
// queue; a monitor pops and compares on every falling edge.
module tb_hazard_stall_controller;

  localparam int AW = 5;
  localparam int CW = 4;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] id_rs, id_rt, idex_rt;
  logic          idex_memread, exmem_branch, exmem_zero;
  logic          exmem_memread, exmem_memwrite, mem_ready;
  logic          pc_write, ifid_write, idex_write, exmem_write, memwb_write;
  logic          ifid_flush, idex_bubble, exmem_bubble, pc_src, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_events;

  always #5 clk = ~clk;

  hazard_stall_controller #(.REG_ADDR_W(AW), .CNT_W(CW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .idex_rt(idex_rt), .idex_memread(idex_memread),
    .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
    .mem_ready(mem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .memwb_write(memwb_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
    .pc_src(pc_src), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_bubble, exmem_bubble, pc_src, mem_timeout}
  localparam logic [9:0] C_OFF = 10'b00000_000_0_0;
  localparam logic [9:0] C_FRZ = 10'b00000_000_0_0;
  localparam logic [9:0] C_RUN = 10'b11111_000_0_0;
  localparam logic [9:0] C_LU  = 10'b00111_010_0_0;
  localparam logic [9:0] C_BR  = 10'b11111_111_1_0;
  localparam logic [9:0] C_FLT = 10'b00000_000_0_1;

  // {idex_memread, exmem_branch, exmem_zero, exmem_memread, exmem_memwrite, mem_ready, reset}
  localparam logic [6:0] F_NONE = 7'b0000000;
  localparam logic [6:0] F_LD   = 7'b1000000;
  localparam logic [6:0] F_BR   = 7'b0110000;
  localparam logic [6:0] F_BRNZ = 7'b0100000;
  localparam logic [6:0] F_RD   = 7'b0001000;
  localparam logic [6:0] F_WR   = 7'b0000100;
  localparam logic [6:0] F_RDY  = 7'b0000010;
  localparam logic [6:0] F_RST  = 7'b0000001;

  typedef struct {
    logic [9:0] ctl;
    int         st;
    int         fl;
    int         idx;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks   = 0;
  int         failures = 0;
  int         step     = 0;
  logic [9:0] act;

  assign act = {pc_write, ifid_write, idex_write, exmem_write, memwb_write,
                ifid_flush, idex_bubble, exmem_bubble, pc_src, mem_timeout};

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks += 3;
      if (act !== mon_e.ctl) begin
        failures++;
        $display("FAIL step%0d ctl actual=%b required=%b", mon_e.idx, act, mon_e.ctl);
      end
      if (stall_cycles !== CW'(mon_e.st)) begin
        failures++;
        $display("FAIL step%0d stall_cycles actual=%0d required=%0d", mon_e.idx, stall_cycles, mon_e.st);
      end
      if (flush_events !== CW'(mon_e.fl)) begin
        failures++;
        $display("FAIL step%0d flush_events actual=%0d required=%0d", mon_e.idx, flush_events, mon_e.fl);
      end
    end
  end

  task automatic vec(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                     input logic [AW-1:0] exrt, input logic [6:0] f,
                     input logic [9:0] ctl, input int st, input int fl);
    exp_t e;
    @(posedge clk); #1;
    id_rs = rs; id_rt = rt; idex_rt = exrt;
    {idex_memread, exmem_branch, exmem_zero, exmem_memread, exmem_memwrite,
     mem_ready, reset} = f;
    e.ctl = ctl; e.st = st; e.fl = fl; e.idx = step;
    sb.push_back(e);
    step++;
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  initial begin
    reset = 1'b1;
    id_rs = '0; id_rt = '0; idex_rt = '0;
    idex_memread = 1'b0; exmem_branch = 1'b0; exmem_zero = 1'b0;
    exmem_memread = 1'b0; exmem_memwrite = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    // reset state and idle
    vec(0, 0, 0, F_RST,  C_OFF, 0, 0);
    vec(1, 2, 3, F_NONE, C_RUN, 0, 0);
    // load-use via rs, then bubble in EX clears it
    vec(8, 0, 8, F_LD,   C_LU,  0, 0);
    vec(8, 0, 8, F_NONE, C_RUN, 1, 0);
    // load into $zero never stalls
    vec(0, 0, 0, F_LD,   C_RUN, 1, 0);
    // load-use via rt
    vec(1, 9, 9, F_LD,   C_LU,  1, 0);
    vec(1, 9, 9, F_NONE, C_RUN, 2, 0);
    // taken branch with simultaneous load-use: branch wins
    vec(8, 0, 8, F_LD | F_BR,   C_BR,  2, 0);
    vec(0, 0, 0, F_NONE,        C_RUN, 2, 1);
    // not-taken branch leaves the load-use stall in place
    vec(8, 0, 8, F_LD | F_BRNZ, C_LU,  2, 1);
    vec(0, 0, 0, F_NONE,        C_RUN, 3, 1);
    // memory wait: 3 frozen cycles then release
    vec(0, 0, 0, F_RD,          C_FRZ, 3, 1);
    vec(0, 0, 0, F_RD,          C_FRZ, 4, 1);
    vec(0, 0, 0, F_RD,          C_FRZ, 5, 1);
    vec(0, 0, 0, F_RD | F_RDY,  C_RUN, 6, 1);
    vec(0, 0, 0, F_NONE,        C_RUN, 6, 1);
    // store wait released together with a taken branch
    vec(0, 0, 0, F_WR,                C_FRZ, 6, 1);
    vec(0, 0, 0, F_WR | F_RDY | F_BR, C_BR,  7, 1);
    vec(0, 0, 0, F_NONE,              C_RUN, 7, 2);
    // reset clears counters
    vec(0, 0, 0, F_RST,  C_OFF, 7, 2);
    vec(0, 0, 0, F_NONE, C_RUN, 0, 0);
    // timeout: MW freeze cycles, then sticky fault
    for (int k = 0; k < MW; k++) vec(0, 0, 0, F_RD, C_FRZ, k, 0);
    vec(0, 0, 0, F_RD,          C_FLT, MW, 0);
    vec(0, 0, 0, F_RD,          C_FLT, MW, 0);
    vec(0, 0, 0, F_RD | F_RDY,  C_FLT, MW, 0);
    vec(8, 0, 8, F_BR | F_LD,   C_FLT, MW, 0);
    vec(0, 0, 0, F_RST,         C_FLT & 10'b0000000001, MW, 0);
    vec(0, 0, 0, F_NONE,        C_RUN, 0, 0);
    // mem_ready in freeze cycle MW avoids the fault
    for (int k = 0; k < MW - 1; k++) vec(0, 0, 0, F_RD, C_FRZ, k, 0);
    vec(0, 0, 0, F_RD | F_RDY,  C_RUN, MW - 1, 0);
    vec(0, 0, 0, F_NONE,        C_RUN, MW - 1, 0);
    // saturation: 20 load-use stalls on a 4-bit counter
    vec(0, 0, 0, F_RST,  C_OFF, MW - 1, 0);
    vec(0, 0, 0, F_NONE, C_RUN, 0, 0);
    for (int k = 0; k < 20; k++) begin
      vec(8, 0, 8, F_LD,   C_LU,  sat15(k), 0);
      vec(8, 0, 8, F_NONE, C_RUN, sat15(k + 1), 0);
    end

    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
